// File: rtl/ctrl_pipe_unit_if.sv
// ctrl_pipe_unit_if: ID-stage inputs and per-stage control outputs of the
// pipelined control unit.
//   master : drives hold_i, the ID-stage fields and reg_equal_i; observes controls
//   slave  : the control unit itself
interface ctrl_pipe_unit_if #(
   parameter int OP_W = 7,
   parameter int RA_W = 5
);
   logic            hold_i;
   logic [OP_W-1:0] op_i;
   logic [RA_W-1:0] rs1_i;
   logic [RA_W-1:0] rs2_i;
   logic [RA_W-1:0] rd_i;
   logic            reg_equal_i;

   logic [1:0]      ex_alu_op_o;
   logic            ex_alu_src_o;
   logic            ex_mem_read_o;
   logic [RA_W-1:0] ex_rd_o;
   logic            mem_mem_read_o;
   logic            mem_mem_write_o;
   logic            mem_reg_write_o;
   logic [RA_W-1:0] mem_rd_o;
   logic            wb_reg_write_o;
   logic            wb_mem_to_reg_o;
   logic [RA_W-1:0] wb_rd_o;
   logic            stall_o;
   logic            flush_o;
   logic            branch_taken_o;
   logic            illegal_o;

   modport master (
      output hold_i, op_i, rs1_i, rs2_i, rd_i, reg_equal_i,
      input  ex_alu_op_o, ex_alu_src_o, ex_mem_read_o, ex_rd_o,
             mem_mem_read_o, mem_mem_write_o, mem_reg_write_o, mem_rd_o,
             wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o,
             stall_o, flush_o, branch_taken_o, illegal_o
   );

   modport slave (
      input  hold_i, op_i, rs1_i, rs2_i, rd_i, reg_equal_i,
      output ex_alu_op_o, ex_alu_src_o, ex_mem_read_o, ex_rd_o,
             mem_mem_read_o, mem_mem_write_o, mem_reg_write_o, mem_rd_o,
             wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o,
             stall_o, flush_o, branch_taken_o, illegal_o
   );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: decodes the ID-stage opcode and carries the control bundle
// through ID/EX, EX/MEM and MEM/WB. Generates the load-use stall (bubble into
// ID/EX) and resolves beq in ID (IF/ID flush + branch select).
// Ports:
//   clk_i  core clock
//   rst_i  asynchronous active-low reset
//   bus    ctrl_pipe_unit_if.slave (ID fields, hold, per-stage controls,
//          stall/flush/branch_taken, sticky illegal)
// Optional build macro CTRL_PERF_CNT_EN adds saturating stall_cnt_o and
// flush_cnt_o counters (CNT_W bits each).
module ctrl_pipe_unit #(
   parameter int OP_W  = 7,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   ctrl_pipe_unit_if.slave bus
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
`endif
);
   localparam logic [OP_W-1:0] OP_NOP  = 7'b0000000;
   localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
   localparam logic [OP_W-1:0] OP_ADDI = 7'b0010011;
   localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;

   if (CNT_W < 2) begin : g_bad_cnt_w
      $error("ctrl_pipe_unit: CNT_W must be at least 2");
   end

   logic [1:0] w_alu_op;
   logic       w_alu_src, w_mem_read, w_mem_write, w_reg_write;
   logic       w_mem_to_reg, w_branch, w_illegal;
   logic       w_stall, w_flush;

   logic [1:0]      r_ex_alu_op;
   logic            r_ex_alu_src, r_ex_mem_read, r_ex_mem_write;
   logic            r_ex_reg_write, r_ex_mem_to_reg;
   logic [RA_W-1:0] r_ex_rd;
   logic            r_mem_mem_read, r_mem_mem_write, r_mem_reg_write, r_mem_mem_to_reg;
   logic [RA_W-1:0] r_mem_rd;
   logic            r_wb_reg_write, r_wb_mem_to_reg;
   logic [RA_W-1:0] r_wb_rd;
   logic            r_illegal;

   always_comb begin
      w_alu_op     = 2'b00;
      w_alu_src    = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_branch     = 1'b0;
      w_illegal    = 1'b0;
      case (bus.op_i)
         OP_NOP:  ;
         OP_R:    begin w_alu_op = 2'b10; w_reg_write = 1'b1; end
         OP_ADDI: begin w_alu_src = 1'b1; w_reg_write = 1'b1; end
         OP_LW:   begin
            w_alu_src = 1'b1; w_mem_read = 1'b1;
            w_reg_write = 1'b1; w_mem_to_reg = 1'b1;
         end
         OP_SW:   begin w_alu_src = 1'b1; w_mem_write = 1'b1; end
         OP_BEQ:  begin w_alu_op = 2'b01; w_branch = 1'b1; end
         default: w_illegal = 1'b1;
      endcase
   end

   // rs2 is compared even for I-type; the occasional false stall is accepted
   assign w_stall = r_ex_mem_read && (r_ex_rd != '0) &&
                    ((r_ex_rd == bus.rs1_i) || (r_ex_rd == bus.rs2_i));
   // a pending load-use stall wins; beq re-resolves once the stall clears
   assign w_flush = w_branch && bus.reg_equal_i && !w_stall;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ex_alu_op      <= 2'b00;
         r_ex_alu_src     <= 1'b0;
         r_ex_mem_read    <= 1'b0;
         r_ex_mem_write   <= 1'b0;
         r_ex_reg_write   <= 1'b0;
         r_ex_mem_to_reg  <= 1'b0;
         r_ex_rd          <= '0;
         r_mem_mem_read   <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_to_reg <= 1'b0;
         r_mem_rd         <= '0;
         r_wb_reg_write   <= 1'b0;
         r_wb_mem_to_reg  <= 1'b0;
         r_wb_rd          <= '0;
         r_illegal        <= 1'b0;
      end else if (!bus.hold_i) begin
         if (w_stall) begin
            r_ex_alu_op     <= 2'b00;
            r_ex_alu_src    <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_rd         <= '0;
         end else begin
            r_ex_alu_op     <= w_alu_op;
            r_ex_alu_src    <= w_alu_src;
            r_ex_mem_read   <= w_mem_read;
            r_ex_mem_write  <= w_mem_write;
            r_ex_reg_write  <= w_reg_write;
            r_ex_mem_to_reg <= w_mem_to_reg;
            r_ex_rd         <= bus.rd_i;
         end
         r_mem_mem_read   <= r_ex_mem_read;
         r_mem_mem_write  <= r_ex_mem_write;
         r_mem_reg_write  <= r_ex_reg_write;
         r_mem_mem_to_reg <= r_ex_mem_to_reg;
         r_mem_rd         <= r_ex_rd;
         r_wb_reg_write   <= r_mem_reg_write;
         r_wb_mem_to_reg  <= r_mem_mem_to_reg;
         r_wb_rd          <= r_mem_rd;
         if (w_illegal && !w_stall) r_illegal <= 1'b1;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (!bus.hold_i) begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`endif

   assign bus.ex_alu_op_o     = r_ex_alu_op;
   assign bus.ex_alu_src_o    = r_ex_alu_src;
   assign bus.ex_mem_read_o   = r_ex_mem_read;
   assign bus.ex_rd_o         = r_ex_rd;
   assign bus.mem_mem_read_o  = r_mem_mem_read;
   assign bus.mem_mem_write_o = r_mem_mem_write;
   assign bus.mem_reg_write_o = r_mem_reg_write;
   assign bus.mem_rd_o        = r_mem_rd;
   assign bus.wb_reg_write_o  = r_wb_reg_write;
   assign bus.wb_mem_to_reg_o = r_wb_mem_to_reg;
   assign bus.wb_rd_o         = r_wb_rd;
   assign bus.stall_o         = w_stall;
   assign bus.flush_o         = w_flush;
   assign bus.branch_taken_o  = w_flush;
   assign bus.illegal_o       = r_illegal;
endmodule
